// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_LENGTH    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 200000;

    // Width needed to hold an index in 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first set request above the pointer wins,
// wrapping around. The pointer register itself lives in the parent.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [PTR_W-1:0]   winner_idx_o
);

    logic [PTR_W-1:0] cand;

    // Walk pointer+1, pointer+2, ... (mod NUM_REQ) and keep the first hit.
    always_comb begin
        valid_o      = 1'b0;
        winner_o     = '0;
        winner_idx_o = '0;
        cand         = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                winner_o[cand] = 1'b1;
                winner_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ clients.
// Optional stalled-frame watchdog is built when UART_ARB_TIMEOUT_EN is defined;
// otherwise timeout_err is tied low but the port remains.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int Data_length    = DEF_DATA_LENGTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk1,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*Data_length-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_parity,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    input  logic                           baud_tick,
    input  logic                           tx_done,
    output logic [Data_length-1:0]         tx_data,
    output logic                           tx_send,
    output logic                           tx_parity_type,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int PTR_W = idx_width(NUM_REQ);

    // Elaboration-time sanity check on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || Data_length < 1) begin : g_param_check
        $error("uart_tx_arbiter: invalid parameter set");
    end

    arb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [Data_length-1:0] tx_data_q, tx_data_d;
    logic                   tx_send_q, tx_send_d;
    logic                   tx_parity_q, tx_parity_d;
    logic                   baud_prev_q, txdone_prev_q;

    logic                   baud_rise, txdone_rise;
    logic                   arb_valid;
    logic [NUM_REQ-1:0]     win_onehot;
    logic [PTR_W-1:0]       win_idx;
    logic                   timeout_hit;

    assign baud_rise   = baud_tick & ~baud_prev_q;
    assign txdone_rise = tx_done & ~txdone_prev_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .valid_o      (arb_valid),
        .winner_o     (win_onehot),
        .winner_idx_o (win_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = idx_width(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_err_q;

    assign timeout_hit = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts only while a frame is in flight; it restarts from zero on every grant.
    always_comb begin
        wd_d = wd_q + 1'b1;
        if (state_q == IDLE || state_d == IDLE) begin
            wd_d = '0;
        end
    end

    // Watchdog counter and its one-cycle expiry pulse.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_hit;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and registered-output logic; watchdog expiry beats frame events.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        done_d      = '0;
        tx_data_d   = tx_data_q;
        tx_send_d   = tx_send_q;
        tx_parity_d = tx_parity_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d       = win_onehot;
                    tx_data_d   = req_data[win_idx*Data_length +: Data_length];
                    tx_parity_d = req_parity[win_idx];
                    tx_send_d   = 1'b1;
                    owner_d     = win_idx;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (timeout_hit) begin
                    tx_send_d = 1'b0;
                    ptr_d     = owner_q;
                    state_d   = IDLE;
                end else if (baud_rise) begin
                    tx_send_d = 1'b0;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (timeout_hit) begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end else if (txdone_rise) begin
                    done_d[owner_q] = 1'b1;
                    ptr_d           = owner_q;
                    state_d         = IDLE;
                end
            end
            default: begin
                tx_send_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State, pointer, output and edge-detect registers.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= PTR_W'(NUM_REQ - 1);
            owner_q       <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            tx_data_q     <= '0;
            tx_send_q     <= 1'b0;
            tx_parity_q   <= 1'b0;
            baud_prev_q   <= 1'b0;
            txdone_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            tx_data_q     <= tx_data_d;
            tx_send_q     <= tx_send_d;
            tx_parity_q   <= tx_parity_d;
            baud_prev_q   <= baud_tick;
            txdone_prev_q <= tx_done;
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign tx_data        = tx_data_q;
    assign tx_send        = tx_send_q;
    assign tx_parity_type = tx_parity_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table of single-client frames,
// hand-written sequences for multi-client, fairness, level-held tx_done, reset
// and (when UART_ARB_TIMEOUT_EN is defined) watchdog cases, with a grant scoreboard.
module tb_uart_tx_arbiter;

    localparam int NR     = 4;
    localparam int DL     = 8;
    localparam int TMO    = 100;
    localparam int BUDGET = 400;

    logic             clk1 = 1'b0;
    logic             rst = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*DL-1:0] req_data = '0;
    logic [NR-1:0]    req_parity = '0;
    logic             baud_tick = 1'b0;
    logic             tx_done = 1'b0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic [DL-1:0]    tx_data;
    logic             tx_send;
    logic             tx_parity_type;
    logic             busy;
    logic             timeout_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         owner;
        logic [7:0] data;
        logic       parity;
    } exp_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       parity;
        logic [3:0] exp_gnt;
        logic [7:0] exp_tx_data;
        logic       exp_parity;
    } vec_t;

    exp_t exp_q[$];
    int   cur_owner = -1;
    int   gnt_seen  = 0;
    int   done_seen = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .Data_length    (DL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk1           (clk1),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .req_parity     (req_parity),
        .gnt            (gnt),
        .done           (done),
        .baud_tick      (baud_tick),
        .tx_done        (tx_done),
        .tx_data        (tx_data),
        .tx_send        (tx_send),
        .tx_parity_type (tx_parity_type),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk1 = ~clk1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every grant pops the next expected owner/byte/parity.
    always @(negedge clk1) begin
        if (rst) begin
            if (gnt != '0) begin
                gnt_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("gnt_unexpected", 32'(gnt), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("sb_gnt", 32'(gnt), 32'(1) << e.owner);
                    checkOutput("sb_tx_data", 32'(tx_data), 32'(e.data));
                    checkOutput("sb_parity", 32'(tx_parity_type), 32'(e.parity));
                    checkOutput("sb_send", 32'(tx_send), 32'h1);
                    cur_owner = e.owner;
                end
            end
            if (done != '0) begin
                done_seen++;
                checkOutput("sb_done", 32'(done), 32'(1) << cur_owner);
                checkOutput("sb_done_gnt_gap", 32'(gnt), 32'h0);
            end
        end
    end

    task automatic doReset();
        rst       = 1'b0;
        req       = '0;
        baud_tick = 1'b0;
        tx_done   = 1'b0;
        repeat (2) @(negedge clk1);
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req_data               = {$urandom};
        req_data[v.idx*DL +: DL] = v.data;
        req_parity             = 4'($urandom);
        req_parity[v.idx]      = v.parity;
        req                    = '0;
        req[v.idx]             = 1'b1;
        exp_q.push_back('{v.idx, v.exp_tx_data, v.exp_parity});
    endtask

    task automatic waitGrant(input int idx, input bit drop, output int cycles);
        cycles = 0;
        while (cycles < BUDGET) begin
            @(negedge clk1);
            cycles++;
            if (gnt[idx]) break;
        end
        checkOutput($sformatf("gnt%0d_seen", idx), 32'(gnt[idx]), 32'h1);
        if (drop) req[idx] = 1'b0;
    endtask

    task automatic finishFrame(input int idx);
        int c;
        @(negedge clk1);
        baud_tick = 1'b1;
        @(negedge clk1);
        checkOutput("send_drop", 32'(tx_send), 32'h0);
        checkOutput("busy_wait", 32'(busy), 32'h1);
        baud_tick = 1'b0;
        @(negedge clk1);
        tx_done = 1'b1;
        c = 0;
        while (c < BUDGET) begin
            @(negedge clk1);
            c++;
            if (done != '0) break;
        end
        checkOutput($sformatf("done%0d", idx), 32'(done), 32'(1) << idx);
        checkOutput("done_latency", 32'(c), 32'h1);
        checkOutput("busy_idle", 32'(busy), 32'h0);
        tx_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vec_t vecs[5];
        int   c;
        int   d0;

        vecs[0] = '{0, 8'h01, 1'b0, 4'b0001, 8'h01, 1'b0};
        vecs[1] = '{1, 8'hA5, 1'b1, 4'b0010, 8'hA5, 1'b1};
        vecs[2] = '{2, 8'h3C, 1'b0, 4'b0100, 8'h3C, 1'b0};
        vecs[3] = '{3, 8'hFF, 1'b1, 4'b1000, 8'hFF, 1'b1};
        vecs[4] = '{2, 8'h5A, 1'b1, 4'b0100, 8'h5A, 1'b1};

        // Reset state
        repeat (2) @(negedge clk1);
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_send", 32'(tx_send), 32'h0);
        checkOutput("rst_data", 32'(tx_data), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_tmo", 32'(timeout_err), 32'h0);
        rst = 1'b1;

        // Single-request vector table
        foreach (vecs[k]) begin
            @(negedge clk1);
            applyStimulus(vecs[k]);
            waitGrant(vecs[k].idx, 1'b1, c);
            checkOutput("gnt_latency", 32'(c), 32'h1);
            checkOutput("vec_gnt", 32'(gnt), 32'(vecs[k].exp_gnt));
            req_data = ~req_data;
            req_parity = ~req_parity;
            @(negedge clk1);
            checkOutput("gnt_pulse", 32'(gnt), 32'h0);
            checkOutput("send_hold", 32'(tx_send), 32'h1);
            repeat (3) @(negedge clk1);
            checkOutput("send_hold_late", 32'(tx_send), 32'h1);
            checkOutput("data_hold", 32'(tx_data), 32'(vecs[k].exp_tx_data));
            checkOutput("parity_hold", 32'(tx_parity_type), 32'(vecs[k].exp_parity));
            finishFrame(vecs[k].idx);
            checkOutput("data_after_frame", 32'(tx_data), 32'(vecs[k].exp_tx_data));
        end

        // All four together, from reset: order 0,1,2,3 with one IDLE cycle between frames
        doReset();
        req_data   = {8'h1F, 8'h0F, 8'h07, 8'h03};
        req_parity = 4'b1010;
        exp_q.push_back('{0, 8'h03, 1'b0});
        exp_q.push_back('{1, 8'h07, 1'b1});
        exp_q.push_back('{2, 8'h0F, 1'b0});
        exp_q.push_back('{3, 8'h1F, 1'b1});
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            waitGrant(k, 1'b1, c);
            checkOutput($sformatf("all4_gap%0d", k), 32'(c), 32'h1);
            finishFrame(k);
        end

        // Fairness: req[0] held, req[2] raised mid-frame
        doReset();
        req_data   = {8'h44, 8'h22, 8'h11, 8'h10};
        req_parity = 4'b0000;
        exp_q.push_back('{0, 8'h10, 1'b0});
        exp_q.push_back('{2, 8'h22, 1'b0});
        exp_q.push_back('{0, 8'h10, 1'b0});
        req = 4'b0001;
        waitGrant(0, 1'b0, c);
        req[2] = 1'b1;
        finishFrame(0);
        waitGrant(2, 1'b1, c);
        checkOutput("fair_next2", 32'(c), 32'h1);
        finishFrame(2);
        waitGrant(0, 1'b1, c);
        checkOutput("fair_then0", 32'(c), 32'h1);
        finishFrame(0);

        // tx_done already high on entry must not complete the frame
        doReset();
        req_data   = {8'h00, 8'h00, 8'h6B, 8'h00};
        req_parity = 4'b0010;
        tx_done    = 1'b1;
        exp_q.push_back('{1, 8'h6B, 1'b1});
        @(negedge clk1);
        req = 4'b0010;
        waitGrant(1, 1'b1, c);
        @(negedge clk1);
        baud_tick = 1'b1;
        @(negedge clk1);
        baud_tick = 1'b0;
        checkOutput("lvl_send_drop", 32'(tx_send), 32'h0);
        d0 = done_seen;
        repeat (6) @(negedge clk1);
        checkOutput("lvl_no_done", 32'(done_seen), 32'(d0));
        checkOutput("lvl_busy", 32'(busy), 32'h1);
        checkOutput("tmo_quiet", 32'(timeout_err), 32'h0);
        tx_done = 1'b0;
        @(negedge clk1);
        tx_done = 1'b1;
        c = 0;
        while (c < BUDGET) begin
            @(negedge clk1);
            c++;
            if (done != '0) break;
        end
        checkOutput("lvl_done", 32'(done), 32'b0010);
        checkOutput("lvl_done_lat", 32'(c), 32'h1);
        tx_done = 1'b0;

        // Reset asserted in WAIT_DONE
        doReset();
        req_data   = {8'h33, 8'h00, 8'h11, 8'h55};
        req_parity = 4'b1000;
        exp_q.push_back('{0, 8'h55, 1'b0});
        req = 4'b0001;
        waitGrant(0, 1'b1, c);
        @(negedge clk1);
        baud_tick = 1'b1;
        @(negedge clk1);
        baud_tick = 1'b0;
        checkOutput("mid_busy", 32'(busy), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'h0);
        checkOutput("mid_rst_data", 32'(tx_data), 32'h0);
        checkOutput("mid_rst_send", 32'(tx_send), 32'h0);
        checkOutput("mid_rst_gnt_done", 32'({gnt, done}), 32'h0);
        req = 4'b1010;
        exp_q.push_back('{1, 8'h11, 1'b0});
        exp_q.push_back('{3, 8'h33, 1'b1});
        @(negedge clk1);
        rst = 1'b1;
        waitGrant(1, 1'b1, c);
        checkOutput("post_rst_first1", 32'(c), 32'h1);
        finishFrame(1);
        waitGrant(3, 1'b1, c);
        finishFrame(3);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: tx_done never comes, no baud tick either
        doReset();
        req_data   = {8'h00, 8'h77, 8'h00, 8'h66};
        req_parity = 4'b0000;
        exp_q.push_back('{0, 8'h66, 1'b0});
        exp_q.push_back('{2, 8'h77, 1'b0});
        req = 4'b0101;
        waitGrant(0, 1'b1, c);
        d0 = done_seen;
        c = 0;
        while (c < BUDGET) begin
            @(negedge clk1);
            c++;
            if (timeout_err) break;
        end
        checkOutput("tmo_cycles", 32'(c), 32'(TMO));
        checkOutput("tmo_send", 32'(tx_send), 32'h0);
        checkOutput("tmo_busy", 32'(busy), 32'h0);
        checkOutput("tmo_no_done", 32'(done_seen), 32'(d0));
        @(negedge clk1);
        checkOutput("tmo_pulse", 32'(timeout_err), 32'h0);
        checkOutput("tmo_next_gnt", 32'(gnt), 32'b0100);
        req[2] = 1'b0;
        finishFrame(2);
`endif

        repeat (2) @(negedge clk1);
        checkOutput("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
